regfile_wb_scheduler: RTL and testbench

Write-back scheduler and scoreboard for the 32x32 integer register file. It arbitrates the register file's single write port between the ALU and load/store write-back requesters using round-robin order, and drives registered write enable, address and data to the file. It also keeps a per-register busy scoreboard and stalls issue on RAW and WAW hazards against pending writes.

---
 rtl/regfile_wb_scheduler.sv | 124 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler
// Purpose  : Round-robin write-back arbiter (ALU / LSU) for the 32x32 integer
//            register file, with a per-register busy scoreboard that stalls
//            issue on RAW and WAW hazards against pending writes.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // issue side
  input  logic            ISS_VALID_i,
  input  logic [4:0]      ISS_RD_i,
  input  logic [4:0]      ISS_RS1_i,
  input  logic [4:0]      ISS_RS2_i,
  output logic            STALL_o,
  // ALU write-back requester
  input  logic            ALU_VALID_i,
  input  logic [4:0]      ALU_RD_i,
  input  logic [XLEN-1:0] ALU_DATA_i,
  output logic            ALU_READY_o,
  // LSU write-back requester
  input  logic            LSU_VALID_i,
  input  logic [4:0]      LSU_RD_i,
  input  logic [XLEN-1:0] LSU_DATA_i,
  output logic            LSU_READY_o,
  // register-file write port
  output logic            WRT_ENA_o,
  output logic [4:0]      WRT_ADDR_o,
  output logic [XLEN-1:0] WRT_DATA_o,
  // status
  output logic [5:0]      PEND_CNT_o,
  output logic            ERR_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            last_q;          // 0 = ALU granted last, 1 = LSU
  logic            wrt_ena_q;
  logic [4:0]      wrt_addr_q;
  logic [XLEN-1:0] wrt_data_q;
  logic [5:0]      pend_cnt_q, pend_cnt_d;
  logic            err_q;

  logic            grant_alu, grant_lsu, grant_any;
  logic [4:0]      grant_rd;
  logic [XLEN-1:0] grant_data;
  logic            iss_accept;

  // Hazard check against the scoreboard; busy_q[0] is always 0 so x0 never stalls.
  assign STALL_o    = ISS_VALID_i & (busy_q[ISS_RS1_i] | busy_q[ISS_RS2_i] | busy_q[ISS_RD_i]);
  assign iss_accept = ISS_VALID_i & ~STALL_o;

  // Round-robin: a lone requester wins; on a tie the one that did not win last.
  // Grants are suppressed while reset is held so no handshake is reported.
  assign grant_alu  = rst_i & ALU_VALID_i & (~LSU_VALID_i | last_q);
  assign grant_lsu  = rst_i & LSU_VALID_i & (~ALU_VALID_i | ~last_q);
  assign grant_any  = grant_alu | grant_lsu;
  assign grant_rd   = grant_alu ? ALU_RD_i   : LSU_RD_i;
  assign grant_data = grant_alu ? ALU_DATA_i : LSU_DATA_i;

  assign ALU_READY_o = grant_alu;
  assign LSU_READY_o = grant_lsu;

  // Next scoreboard: clear the register being written this cycle, then set the
  // newly issued destination so a coincident set overrides the clear.
  always_comb begin
    busy_d = busy_q;
    if (wrt_ena_q) begin
      busy_d[wrt_addr_q] = 1'b0;
    end
    if (iss_accept && (ISS_RD_i != 5'd0)) begin
      busy_d[ISS_RD_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Population count of the next scoreboard, registered as the pending count.
  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_cnt_d = pend_cnt_d + 6'(busy_d[i]);
    end
  end

  // Scoreboard, arbitration pointer, write port and error flag state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q     <= '0;
      last_q     <= 1'b1;
      wrt_ena_q  <= 1'b0;
      wrt_addr_q <= '0;
      wrt_data_q <= '0;
      pend_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      if (grant_any) begin
        last_q     <= grant_lsu;
        wrt_ena_q  <= (grant_rd != 5'd0);
        wrt_addr_q <= grant_rd;
        wrt_data_q <= grant_data;
        // A write to a register nobody issued is a protocol error; it still lands.
        if ((grant_rd != 5'd0) && !busy_q[grant_rd]) begin
          err_q <= 1'b1;
        end
      end else begin
        wrt_ena_q <= 1'b0;
      end
    end
  end

  assign WRT_ENA_o  = wrt_ena_q;
  assign WRT_ADDR_o = wrt_addr_q;
  assign WRT_DATA_o = wrt_data_q;
  assign PEND_CNT_o = pend_cnt_q;
  assign ERR_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_scheduler
// Purpose  : Directed self-checking bench for regfile_wb_scheduler; expected
//            register-file writes go through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            ISS_VALID_i;
  logic [4:0]      ISS_RD_i, ISS_RS1_i, ISS_RS2_i;
  logic            STALL_o;
  logic            ALU_VALID_i;
  logic [4:0]      ALU_RD_i;
  logic [XLEN-1:0] ALU_DATA_i;
  logic            ALU_READY_o;
  logic            LSU_VALID_i;
  logic [4:0]      LSU_RD_i;
  logic [XLEN-1:0] LSU_DATA_i;
  logic            LSU_READY_o;
  logic            WRT_ENA_o;
  logic [4:0]      WRT_ADDR_o;
  logic [XLEN-1:0] WRT_DATA_o;
  logic [5:0]      PEND_CNT_o;
  logic            ERR_o;

  typedef struct packed {
    logic            ena;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 clk_i = ~clk_i;

  regfile_wb_scheduler #(.XLEN(XLEN), .NREG(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ISS_VALID_i(ISS_VALID_i), .ISS_RD_i(ISS_RD_i), .ISS_RS1_i(ISS_RS1_i),
    .ISS_RS2_i(ISS_RS2_i), .STALL_o(STALL_o),
    .ALU_VALID_i(ALU_VALID_i), .ALU_RD_i(ALU_RD_i), .ALU_DATA_i(ALU_DATA_i),
    .ALU_READY_o(ALU_READY_o),
    .LSU_VALID_i(LSU_VALID_i), .LSU_RD_i(LSU_RD_i), .LSU_DATA_i(LSU_DATA_i),
    .LSU_READY_o(LSU_READY_o),
    .WRT_ENA_o(WRT_ENA_o), .WRT_ADDR_o(WRT_ADDR_o), .WRT_DATA_o(WRT_DATA_o),
    .PEND_CNT_o(PEND_CNT_o), .ERR_o(ERR_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic iss(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ISS_VALID_i = v; ISS_RD_i = rd; ISS_RS1_i = rs1; ISS_RS2_i = rs2;
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    ALU_VALID_i = v; ALU_RD_i = rd; ALU_DATA_i = d;
    #1;
  endtask

  task automatic lsu(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    LSU_VALID_i = v; LSU_RD_i = rd; LSU_DATA_i = d;
    #1;
  endtask

  task automatic push(input logic ena, input logic [4:0] addr, input logic [XLEN-1:0] data);
    wb_t e;
    e.ena = ena; e.addr = addr; e.data = data;
    sb_q.push_back(e);
  endtask

  // Compare the write port against the oldest expected write.
  task automatic chk_wb(input string tag);
    wb_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_ena"},  32'(WRT_ENA_o),  32'(e.ena));
      chk({tag, "_addr"}, 32'(WRT_ADDR_o), 32'(e.addr));
      chk({tag, "_data"}, WRT_DATA_o,      e.data);
    end
  endtask

  initial begin
    rst_i = 1'b0;
    iss(1'b0, 5'd0, 5'd0, 5'd0);
    alu(1'b0, 5'd0, '0);
    lsu(1'b0, 5'd0, '0);
    tick(); tick();
    chk("rst_wrt_ena", 32'(WRT_ENA_o), 32'd0);
    chk("rst_wrt_addr", 32'(WRT_ADDR_o), 32'd0);
    chk("rst_wrt_data", WRT_DATA_o, 32'd0);
    chk("rst_pend", 32'(PEND_CNT_o), 32'd0);
    chk("rst_err", 32'(ERR_o), 32'd0);
    rst_i = 1'b1;
    tick();

    // Basic issue then ALU write-back of x5.
    iss(1'b1, 5'd5, 5'd0, 5'd0);
    chk("iss5_stall", 32'(STALL_o), 32'd0);
    tick();
    iss(1'b0, 5'd0, 5'd0, 5'd0);
    chk("iss5_pend", 32'(PEND_CNT_o), 32'd1);
    alu(1'b1, 5'd5, 32'hDEADBEEF);
    chk("wb5_alu_ready", 32'(ALU_READY_o), 32'd1);
    chk("wb5_lsu_ready", 32'(LSU_READY_o), 32'd0);
    push(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    alu(1'b0, 5'd0, '0);
    chk_wb("wb5");
    chk("wb5_pend_hold", 32'(PEND_CNT_o), 32'd1);
    tick();
    chk("wb5_ena_drop", 32'(WRT_ENA_o), 32'd0);
    chk("wb5_pend_clear", 32'(PEND_CNT_o), 32'd0);

    // WAW and RAW stalls on x3.
    iss(1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    iss(1'b1, 5'd3, 5'd0, 5'd0);
    chk("waw_stall", 32'(STALL_o), 32'd1);
    iss(1'b1, 5'd10, 5'd3, 5'd0);
    chk("raw_stall", 32'(STALL_o), 32'd1);
    tick();
    chk("raw_stall_hold", 32'(STALL_o), 32'd1);
    alu(1'b1, 5'd3, 32'h0000_0033);
    chk("raw_stall_grant", 32'(STALL_o), 32'd1);
    push(1'b1, 5'd3, 32'h0000_0033);
    tick();
    alu(1'b0, 5'd0, '0);
    chk_wb("wb3");
    chk("raw_stall_write", 32'(STALL_o), 32'd1);
    tick();
    chk("raw_release", 32'(STALL_o), 32'd0);
    iss(1'b0, 5'd0, 5'd0, 5'd0);
    chk("raw_pend", 32'(PEND_CNT_o), 32'd0);

    // Sustained contention right after reset: ALU, LSU, ALU, LSU.
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    iss(1'b1, 5'd1, 5'd0, 5'd0); tick();
    iss(1'b1, 5'd2, 5'd0, 5'd0); tick();
    iss(1'b1, 5'd4, 5'd0, 5'd0); tick();
    iss(1'b1, 5'd6, 5'd0, 5'd0); tick();
    iss(1'b0, 5'd0, 5'd0, 5'd0);
    chk("rr_pend4", 32'(PEND_CNT_o), 32'd4);
    alu(1'b1, 5'd1, 32'hA1A1_A1A1);
    lsu(1'b1, 5'd2, 32'hB2B2_B2B2);
    chk("rr1_alu", 32'(ALU_READY_o), 32'd1);
    chk("rr1_lsu", 32'(LSU_READY_o), 32'd0);
    push(1'b1, 5'd1, 32'hA1A1_A1A1);
    tick();
    alu(1'b1, 5'd4, 32'hA4A4_A4A4);
    chk_wb("rr1");
    chk("rr2_alu", 32'(ALU_READY_o), 32'd0);
    chk("rr2_lsu", 32'(LSU_READY_o), 32'd1);
    push(1'b1, 5'd2, 32'hB2B2_B2B2);
    tick();
    lsu(1'b1, 5'd6, 32'hB6B6_B6B6);
    chk_wb("rr2");
    chk("rr3_alu", 32'(ALU_READY_o), 32'd1);
    chk("rr3_lsu", 32'(LSU_READY_o), 32'd0);
    push(1'b1, 5'd4, 32'hA4A4_A4A4);
    tick();
    chk_wb("rr3");
    chk("rr4_alu", 32'(ALU_READY_o), 32'd0);
    chk("rr4_lsu", 32'(LSU_READY_o), 32'd1);
    push(1'b1, 5'd6, 32'hB6B6_B6B6);
    tick();
    alu(1'b0, 5'd0, '0);
    lsu(1'b0, 5'd0, '0);
    chk_wb("rr4");
    tick();
    chk("rr_err", 32'(ERR_o), 32'd0);
    chk("rr_pend0", 32'(PEND_CNT_o), 32'd0);

    // Issue of x7 held across the edge that clears x7.
    iss(1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    iss(1'b0, 5'd0, 5'd0, 5'd0);
    alu(1'b1, 5'd7, 32'h0000_0077);
    push(1'b1, 5'd7, 32'h0000_0077);
    tick();
    alu(1'b0, 5'd0, '0);
    chk_wb("wb7");
    iss(1'b1, 5'd7, 5'd0, 5'd0);
    chk("x7_stall_clear_cycle", 32'(STALL_o), 32'd1);
    chk("x7_pend_before", 32'(PEND_CNT_o), 32'd1);
    tick();
    chk("x7_stall_released", 32'(STALL_o), 32'd0);
    chk("x7_pend_clear", 32'(PEND_CNT_o), 32'd0);
    tick();
    iss(1'b0, 5'd0, 5'd0, 5'd0);
    chk("x7_pend_reissue", 32'(PEND_CNT_o), 32'd1);

    // rd=0 write-back is harmless; write to a non-busy register is an error.
    lsu(1'b1, 5'd0, 32'h0000_CAFE);
    chk("x0_lsu_ready", 32'(LSU_READY_o), 32'd1);
    push(1'b0, 5'd0, 32'h0000_CAFE);
    tick();
    lsu(1'b0, 5'd0, '0);
    chk_wb("wb0");
    chk("x0_err", 32'(ERR_o), 32'd0);
    alu(1'b1, 5'd9, 32'h0000_0099);
    push(1'b1, 5'd9, 32'h0000_0099);
    tick();
    alu(1'b0, 5'd0, '0);
    chk_wb("wb9");
    chk("x9_err_set", 32'(ERR_o), 32'd1);
    tick(); tick();
    chk("x9_err_sticky", 32'(ERR_o), 32'd1);

    // Asynchronous reset with three busy registers and requests pending.
    iss(1'b1, 5'd11, 5'd0, 5'd0); tick();
    iss(1'b1, 5'd12, 5'd0, 5'd0); tick();
    iss(1'b1, 5'd0, 5'd11, 5'd0);
    chk("pre_rst_pend3", 32'(PEND_CNT_o), 32'd3);
    chk("pre_rst_stall", 32'(STALL_o), 32'd1);
    alu(1'b1, 5'd13, 32'h1313_1313);
    lsu(1'b1, 5'd14, 32'h1414_1414);
    rst_i = 1'b0;
    #1;
    chk("arst_wrt_ena", 32'(WRT_ENA_o), 32'd0);
    chk("arst_wrt_addr", 32'(WRT_ADDR_o), 32'd0);
    chk("arst_wrt_data", WRT_DATA_o, 32'd0);
    chk("arst_pend", 32'(PEND_CNT_o), 32'd0);
    chk("arst_err", 32'(ERR_o), 32'd0);
    chk("arst_alu_ready", 32'(ALU_READY_o), 32'd0);
    chk("arst_lsu_ready", 32'(LSU_READY_o), 32'd0);
    chk("arst_stall", 32'(STALL_o), 32'd0);
    tick();
    chk("arst_no_write", 32'(WRT_ENA_o), 32'd0);
    rst_i = 1'b1;
    #1;
    chk("post_rst_alu", 32'(ALU_READY_o), 32'd1);
    chk("post_rst_lsu", 32'(LSU_READY_o), 32'd0);
    chk("post_rst_stall", 32'(STALL_o), 32'd0);
    push(1'b1, 5'd13, 32'h1313_1313);
    tick();
    iss(1'b0, 5'd0, 5'd0, 5'd0);
    alu(1'b0, 5'd0, '0);
    lsu(1'b0, 5'd0, '0);
    chk_wb("post_rst_wb");
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
